// File: rtl/scr_reader_pkg.sv
//------------------------------------------------------------------------------
// Module      : scr_reader_pkg
// Description : Shared framebuffer geometry, ack timing and FSM encoding for
//               the display fetch engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package scr_reader_pkg;

    // 32 lines x 8 bytes; the CPU maps this window at address 0x100.
    localparam int unsigned c_FB_BYTES    = 256;
    localparam int unsigned c_SCR_ACK_GAP = 2;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_WAIT = 3'd2;
    localparam logic [2:0] c_ST_EMIT = 3'd3;
    localparam logic [2:0] c_ST_GAP  = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;

endpackage

`default_nettype wire

// File: rtl/scr_reader.sv
//------------------------------------------------------------------------------
// Module      : scr_reader
// Description : Fetches the 256-byte CHIP-8 framebuffer through the CPU read
//               handshake on each frame request and streams it to a byte sink.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scr_reader
    import scr_reader_pkg::*;
#(
    parameter bit RELEASE_ON_STALL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    output logic       scr_busy,
    output logic       scr_read,
    output logic [7:0] scr_read_idx,
    input  logic [7:0] scr_read_byte,
    input  logic       scr_read_ack,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_first,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_overrun
);

    localparam logic [7:0] c_LAST_IDX = 8'(c_FB_BYTES - 1);
    localparam logic [0:0] c_GAP_LAST = 1'(c_SCR_ACK_GAP - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_idx;
    logic [7:0] w_idx_nxt;
    logic [7:0] r_byte;
    logic [7:0] w_byte_nxt;
    logic [0:0] r_gap;
    logic [0:0] w_gap_nxt;
    logic       r_pending;
    logic       w_pending_nxt;
    logic       r_overrun;
    logic       w_overrun_nxt;
    logic       w_take;
    logic       w_in_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_idx     <= 8'd0;
            r_byte    <= 8'd0;
            r_gap     <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_byte    <= w_byte_nxt;
            r_gap     <= w_gap_nxt;
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_byte_nxt  = r_byte;
        w_gap_nxt   = r_gap;
        w_take      = 1'b0;

        // Acks are only honoured in WAIT; late duplicates land harmlessly elsewhere.
        case (r_state)
            c_ST_IDLE: begin
                if (r_pending) begin
                    w_state_nxt = c_ST_REQ;
                    w_idx_nxt   = 8'd0;
                    w_take      = 1'b1;
                end
            end
            c_ST_REQ: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (scr_read_ack) begin
                    w_byte_nxt  = scr_read_byte;
                    w_state_nxt = c_ST_EMIT;
                end
            end
            c_ST_EMIT: begin
                if (out_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_gap_nxt   = 1'b0;
                        w_state_nxt = c_ST_GAP;
                    end
                end
            end
            c_ST_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = c_ST_REQ;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // A request landing in the same cycle the latch is consumed is queued, not dropped.
        w_pending_nxt = (r_pending && !w_take) || frame_start;
        w_overrun_nxt = frame_start && r_pending && !w_take;
    end

    assign w_in_frame = (r_state == c_ST_REQ) || (r_state == c_ST_WAIT) ||
                        (r_state == c_ST_EMIT) || (r_state == c_ST_GAP);

    assign scr_busy      = w_in_frame &&
                           !(RELEASE_ON_STALL && (r_state == c_ST_EMIT) && !out_ready);
    assign scr_read      = (r_state == c_ST_WAIT);
    assign scr_read_idx  = r_idx;
    assign out_valid     = (r_state == c_ST_EMIT);
    assign out_byte      = r_byte;
    assign out_first     = out_valid && (r_idx == 8'd0);
    assign out_last      = out_valid && (r_idx == c_LAST_IDX);
    assign frame_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_scr_reader.sv
//------------------------------------------------------------------------------
// Module      : tb_scr_reader
// Description : Randomised bench for scr_reader with a CPU responder model and
//               a byte-stream scoreboard; two instances cover both stall modes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_scr_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       scr_read_ack;
    logic [7:0] scr_read_byte;
    logic       out_ready;

    logic       busy0, rd0, valid0, first0, last0, ovr0;
    logic [7:0] idx0, byte0;
    logic       busy1, rd1, valid1, first1, last1, ovr1;
    logic [7:0] idx1, byte1;

    logic [7:0] fb [256];

    int   checks = 0;
    int   errors = 0;
    int   bytes_seen = 0;
    int   stall_cycles = 0;
    int   ovr_seen = 0;
    logic [7:0] exp_idx, exp_rd, held_byte, frame_first_byte, frame_last_byte;
    logic prev_rd, prev_stall, prev_ack;

    logic hold, dup_en, rand_lat, first_lat, rand_ready, stray_req;

    always #5 clk = ~clk;

    scr_reader #(.RELEASE_ON_STALL(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .scr_busy(busy0), .scr_read(rd0), .scr_read_idx(idx0),
        .scr_read_byte(scr_read_byte), .scr_read_ack(scr_read_ack),
        .out_valid(valid0), .out_byte(byte0), .out_first(first0), .out_last(last0),
        .out_ready(out_ready), .frame_overrun(ovr0)
    );

    scr_reader #(.RELEASE_ON_STALL(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .scr_busy(busy1), .scr_read(rd1), .scr_read_idx(idx1),
        .scr_read_byte(scr_read_byte), .scr_read_ack(scr_read_ack),
        .out_valid(valid1), .out_byte(byte1), .out_first(first1), .out_last(last1),
        .out_ready(out_ready), .frame_overrun(ovr1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CPU responder: acks after a latency, optional echo ack one cycle later.
    int   cnt = 0;
    int   cur_lat = 2;
    logic acked = 1'b0;
    logic dup_due = 1'b0;
    always @(posedge clk) begin
        #1;
        scr_read_ack  = 1'b0;
        scr_read_byte = 8'($urandom);
        if (reset) begin
            cnt = 0; acked = 1'b0; dup_due = 1'b0;
        end else begin
            if (dup_due) begin
                scr_read_ack = 1'b1;
                dup_due      = 1'b0;
            end
            if (rd0 && !acked && !hold) begin
                if (cnt == 0)
                    cur_lat = (first_lat && idx0 == 8'd0) ? 300 :
                              (rand_lat ? int'($urandom_range(1, 4)) : 2);
                cnt++;
                if (cnt >= cur_lat) begin
                    scr_read_ack  = 1'b1;
                    scr_read_byte = fb[idx0];
                    acked         = 1'b1;
                    dup_due       = dup_en;
                    cnt           = 0;
                end
            end else if (!rd0) begin
                acked = 1'b0;
                cnt   = 0;
            end
        end
        if (stray_req) begin
            scr_read_ack = 1'b1;
            stray_req    = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    end

    // Scoreboard: bytes must appear in index order, each exactly once.
    always @(negedge clk) begin
        if (reset) begin
            exp_idx = 8'd0; exp_rd = 8'd0;
            prev_rd = 1'b0; prev_stall = 1'b0; prev_ack = 1'b0;
        end else begin
            if (prev_ack) chk("ack_to_valid", 64'({valid0, valid1}), 64'(2'b11));
            prev_ack = scr_read_ack && rd0;

            if (valid0 && out_ready) begin
                chk("out_byte", 64'({byte0, byte1}), 64'({fb[exp_idx], fb[exp_idx]}));
                chk("out_first", 64'({first0, first1}), 64'({2{exp_idx == 8'd0}}));
                chk("out_last", 64'({last0, last1}), 64'({2{exp_idx == 8'd255}}));
                chk("busy_xfer", 64'({busy0, busy1}), 64'(2'b11));
                if (exp_idx == 8'd0)   frame_first_byte = byte0;
                if (exp_idx == 8'd255) frame_last_byte  = byte0;
                exp_idx = exp_idx + 8'd1;
                bytes_seen++;
            end

            if (valid0 && !out_ready) begin
                if (prev_stall) chk("stall_hold", 64'({byte0, byte1}), 64'({held_byte, held_byte}));
                chk("busy_stall", 64'({busy0, busy1}), 64'(2'b10));
                held_byte  = fb[exp_idx];
                prev_stall = 1'b1;
                stall_cycles++;
            end else begin
                prev_stall = 1'b0;
            end

            if (!valid0)
                chk("qual_idle", 64'({valid1, first0, last0, first1, last1}), 64'(0));

            if (rd0) begin
                if (!prev_rd) exp_rd = exp_rd + 8'd1;
                chk("read_idx", 64'({rd1, idx0, idx1}), 64'({1'b1, 8'(exp_rd - 8'd1), 8'(exp_rd - 8'd1)}));
                chk("busy_read", 64'({busy0, busy1}), 64'(2'b11));
            end
            prev_rd = rd0;

            if (ovr0 || ovr1) begin
                chk("ovr_pair", 64'({ovr0, ovr1}), 64'(2'b11));
                ovr_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_bytes(input string name, input int target, input int budget);
        int n = 0;
        while (bytes_seen < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(bytes_seen), 64'(target));
    endtask

    task automatic wait_done(input string name);
        @(negedge clk);
        chk(name, 64'({busy0, busy1, rd0, valid0}), 64'(0));
        tick();
        tick();
        chk("read_count", 64'(exp_rd), 64'(0));
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 64'({busy0, rd0, idx0, valid0, byte0, first0, last0, ovr0}), 64'(0));
        chk(name, 64'({busy1, rd1, idx1, valid1, byte1, first1, last1, ovr1}), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n;
        int ovr_mark;
        int stall_mark;
        reset = 1'b1; frame_start = 1'b0; out_ready = 1'b1;
        hold = 1'b0; dup_en = 1'b0; rand_lat = 1'b0; first_lat = 1'b0;
        rand_ready = 1'b0; stray_req = 1'b0;
        scr_read_ack = 1'b0; scr_read_byte = 8'd0;
        for (int i = 0; i < 256; i++) fb[i] = 8'(i) ^ 8'h5A;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_out");
        tick();
        reset = 1'b0;
        tick();

        // Single frame, fixed latency, startup timing pinned cycle by cycle
        base = bytes_seen;
        pulse_start();
        @(negedge clk); chk("busy_lat0", 64'(busy0), 64'(0));
        @(negedge clk); chk("busy_lat1", 64'({busy0, rd0}), 64'(2'b10));
        @(negedge clk); chk("read_lat", 64'({rd0, idx0}), 64'({1'b1, 8'h00}));
        wait_bytes("frame1_bytes", base + 256, 4000);
        chk("first_literal", 64'(frame_first_byte), 64'(8'h5A));
        chk("last_literal", 64'(frame_last_byte), 64'(8'hA5));
        wait_done("frame1_done");

        // Echo ack after every read
        dup_en = 1'b1;
        base = bytes_seen;
        pulse_start();
        wait_bytes("dup_bytes", base + 256, 4000);
        wait_done("dup_done");
        dup_en = 1'b0;

        // 50-cycle sink stall at byte 17
        base = bytes_seen;
        pulse_start();
        wait_bytes("stall_pre", base + 17, 1000);
        out_ready = 1'b0;
        stall_mark = stall_cycles;
        repeat (50) tick();
        chk("stall_len", 64'(stall_cycles - stall_mark >= 40), 64'(1));
        out_ready = 1'b1;
        wait_bytes("stall_bytes", base + 256, 4000);
        wait_done("stall_done");

        // Requests during an active frame: one queued, one dropped
        base = bytes_seen;
        ovr_mark = ovr_seen;
        pulse_start();
        wait_bytes("ovr_pre100", base + 100, 2000);
        pulse_start();
        tick();
        chk("no_overrun", 64'(ovr_seen - ovr_mark), 64'(0));
        wait_bytes("ovr_pre150", base + 150, 2000);
        pulse_start();
        tick();
        chk("overrun_pulse", 64'(ovr_seen - ovr_mark), 64'(1));
        wait_bytes("ovr_frame1", base + 256, 2000);
        tick();
        tick();
        @(negedge clk); chk("back_to_back", 64'(busy0), 64'(1));
        wait_bytes("ovr_total", base + 512, 4000);
        wait_done("ovr_done");
        chk("overrun_count", 64'(ovr_seen - ovr_mark), 64'(1));

        // Reset while waiting on the ack for byte 40, then a stray ack
        base = bytes_seen;
        pulse_start();
        wait_bytes("rst_pre", base + 40, 1000);
        hold = 1'b1;
        n = 0;
        while (!(rd0 && idx0 == 8'd40) && n < 50) begin tick(); n++; end
        chk("rst_at_wait", 64'({rd0, idx0}), 64'({1'b1, 8'd40}));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_mid");
        tick();
        reset = 1'b0;
        @(negedge clk);
        stray_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stray_ignored", 64'({valid0, rd0, busy0}), 64'(0));
        end
        hold = 1'b0;
        tick();
        base = bytes_seen;
        frame_first_byte = 8'd0;
        pulse_start();
        wait_bytes("restart_bytes", base + 256, 4000);
        chk("restart_first", 64'(frame_first_byte), 64'(8'h5A));
        wait_done("restart_done");

        // First ack of the frame delayed by 300 cycles
        first_lat = 1'b1;
        base = bytes_seen;
        pulse_start();
        wait_bytes("slow_bytes", base + 256, 4500);
        wait_done("slow_done");
        first_lat = 1'b0;

        // Randomised frames: content, latency, backpressure, echo acks
        rand_lat = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
            dup_en = 1'($urandom_range(0, 1));
            base = bytes_seen;
            pulse_start();
            wait_bytes("rand_bytes", base + 256, 6000);
            wait_done("rand_done");
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        dup_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
